// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int              STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  // Saturating increment for the per-requester beat counters.
  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set req_valid bit at or after
// rr_ptr, searching upward with wrap.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  int idx;

  // Scan from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win_onehot = '0;
    win_idx    = '0;
    idx        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req_valid[idx]) begin
        win_onehot      = '0;
        win_onehot[idx] = 1'b1;
        win_idx         = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// requesters, granting bounded bursts of up to MAX_BURST beats gated by full.
// Optional feature macro: WR_ARB_STATS_EN (per-requester saturating beat counters).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [WIDTH-1:0]          fifo_wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam int                BEAT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   owner_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_valid;
  logic               beat_acc;
  logic               burst_end;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx)
  );

  assign owner_valid = req_valid[owner_idx];
  assign beat_acc    = (state == BURST) && owner_valid && !fifo_full;
  assign burst_end   = (state == BURST) &&
                       (!owner_valid || (beat_acc && (beat_cnt == LAST_BEAT)));
  assign busy        = (state == BURST);

  // Write-port mux: the owner's handshake and data, driven only during a burst.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (state == BURST) begin
      req_ready[owner_idx] = !fifo_full;
      fifo_wr_en           = beat_acc;
      fifo_wr_data         = req_data[int'(owner_idx)*WIDTH +: WIDTH];
    end
  end

  // Arbitration FSM: grant in IDLE, count beats in BURST, rotate the pointer on exit.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (wr_rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= pick_onehot;
            owner_idx <= pick_idx;
            state     <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;
          end else if (beat_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  // Per-requester accepted-beat counters, saturating, cleared only by reset.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    // NOTE: this small counter array is reset explicitly because its value is architecturally visible.
    if (wr_rst) begin
      for (int k = 0; k < NUM_REQ; k++) stat_q[k] <= '0;
    end else if (beat_acc) begin
      stat_q[owner_idx] <= stat_sat_inc(stat_q[owner_idx]);
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    assign stat_cnt[k*STAT_W +: STAT_W] = stat_q[k];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: randomized requesters feed a
// scoreboard; a separate monitor checks the write stream against a
// round-robin reference model. Honours WR_ARB_STATS_EN when defined.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic                     wr_clk = 1'b0;
  logic                     wr_rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full = 1'b0;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [NUM_REQ*16-1:0]    stat_cnt;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy),
    .stat_cnt     (stat_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // Expected beats per requester, in the order they were offered.
  logic [WIDTH-1:0]   exp_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] will_acc = '0;
  int                 wr_count = 0;
  logic               seq_mode = 1'b0;
  logic [WIDTH-1:0]   seq_next = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference rule: first valid requester at or after ptr, wrapping upward.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return 0;
  endfunction

  // One clock of stimulus: retire accepted beats, maybe offer new ones, set full.
  task automatic step(input bit rst, input int p_offer, input int p_full,
                      input logic [NUM_REQ-1:0] mask);
    logic [WIDTH-1:0] d;
    @(negedge wr_clk);
    wr_rst = rst;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (will_acc[k]) req_valid[k] = 1'b0;
      if (!req_valid[k] && mask[k] && (int'($urandom_range(99)) < p_offer)) begin
        d = seq_mode ? seq_next : WIDTH'($urandom);
        if (seq_mode) seq_next = seq_next + 1'b1;
        req_valid[k]               = 1'b1;
        req_data[k*WIDTH +: WIDTH] = d;
        exp_q[k].push_back(d);
      end
    end
    fifo_full = (int'($urandom_range(99)) < p_full);
    #1 will_acc = req_valid & req_ready;
  endtask

  // Stop offering and let every held beat drain, with a cycle budget.
  task automatic drain();
    int n;
    n = 0;
    while (((req_valid != '0) || busy) && (n < 200)) begin
      step(1'b0, 0, 0, '0);
      n++;
    end
    check("drain_within_budget", 64'(n < 200), 64'd1);
  endtask

  // Monitor: reference model of bursts, rotation and the write stream.
  initial begin : monitor
    int                 owner;
    int                 beats;
    int                 model_ptr;
    int                 stat_model [NUM_REQ];
    logic               prev_busy;
    logic               prev_end;
    logic               exp_busy;
    logic               acc;
    logic [NUM_REQ-1:0] prev_valid;
    logic [63:0]        stat_exp;
    logic [WIDTH-1:0]   exp_d;
    owner      = 0;
    beats      = 0;
    model_ptr  = 0;
    prev_busy  = 1'b0;
    prev_end   = 1'b0;
    prev_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) stat_model[k] = 0;
    forever begin
      @(negedge wr_clk);
      #2;
      wr_count += int'(fifo_wr_en);
      if (wr_rst) begin
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
        check("rst_stat_cnt", stat_cnt, 64'd0);
        model_ptr  = 0;
        prev_busy  = 1'b0;
        prev_end   = 1'b0;
        prev_valid = '0;
        beats      = 0;
        for (int k = 0; k < NUM_REQ; k++) stat_model[k] = 0;
      end else begin
        stat_exp = '0;
`ifdef WR_ARB_STATS_EN
        for (int k = 0; k < NUM_REQ; k++) stat_exp[k*16 +: 16] = 16'(stat_model[k]);
`endif
        check("stat_cnt", stat_cnt, stat_exp);
        exp_busy = prev_busy ? !prev_end : (prev_valid != '0);
        check("busy", 64'(busy), 64'(exp_busy));
        if (exp_busy && !prev_busy) begin
          owner = rr_pick(prev_valid, model_ptr);
          beats = 0;
        end
        if (!exp_busy && prev_busy) model_ptr = (owner + 1) % NUM_REQ;
        prev_end = 1'b0;
        if (exp_busy) begin
          acc = req_valid[owner] && !fifo_full;
          check("grant", 64'(grant), 64'(onehot(owner)));
          check("req_ready", 64'(req_ready), fifo_full ? 64'd0 : 64'(onehot(owner)));
          check("wr_en", 64'(fifo_wr_en), 64'(acc));
          if (acc) begin
            if (exp_q[owner].size() == 0) begin
              check("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
              exp_d = exp_q[owner].pop_front();
              check("wr_data", 64'(fifo_wr_data), 64'(exp_d));
            end
            beats++;
            stat_model[owner]++;
          end
          prev_end = !req_valid[owner] || (acc && (beats == MAX_BURST));
        end else begin
          check("idle_grant", 64'(grant), 64'd0);
          check("idle_req_ready", 64'(req_ready), 64'd0);
          check("idle_wr_en", 64'(fifo_wr_en), 64'd0);
        end
        prev_busy  = exp_busy;
        prev_valid = req_valid;
      end
    end
  end

  typedef struct {
    int offer;
    int full;
    int cycles;
  } phase_t;

  initial begin : stimulus
    phase_t phases [4];
    int     c0;
    phases[0] = '{70, 20, 400};
    phases[1] = '{30, 0, 400};
    phases[2] = '{90, 40, 400};
    phases[3] = '{50, 10, 400};

    // Reset held with every requester valid, then back-to-back fairness window.
    repeat (3) step(1'b1, 100, 0, 4'b1111);
    #2 c0 = wr_count;
    repeat (25) step(1'b0, 100, 0, 4'b1111);
    #2 check("fairness_writes_in_25_clk", 64'(wr_count - c0), 64'd20);
    drain();

    // Single requester, sequential data from 8'h10.
    seq_mode = 1'b1;
    seq_next = 8'h10;
    repeat (12) step(1'b0, 100, 0, 4'b0010);
    drain();

    // Full stall after beat 2 for three cycles.
    repeat (3) step(1'b0, 100, 0, 4'b0010);
    repeat (3) step(1'b0, 100, 100, 4'b0010);
    repeat (6) step(1'b0, 100, 0, 4'b0010);
    seq_mode = 1'b0;
    drain();

    // Early end: requester 2 stops after two beats while 3 is pending.
    repeat (2) step(1'b1, 0, 0, '0);
    repeat (3) step(1'b0, 100, 0, 4'b1100);
    repeat (3) step(1'b0, 100, 0, 4'b1000);
    check("early_end_next_grant", 64'(grant), 64'(4'b1000));
    drain();

    // Reset in the middle of a burst.
    repeat (2) step(1'b1, 100, 0, 4'b1111);
    repeat (3) step(1'b0, 100, 0, 4'b1111);
    step(1'b1, 100, 0, 4'b1111);
    check("mid_burst_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    step(1'b1, 100, 0, 4'b1111);
    repeat (2) step(1'b0, 100, 0, 4'b1111);
    check("post_rst_first_grant", 64'(grant), 64'(4'b0001));
    drain();

    // Randomized phases.
    foreach (phases[p]) begin
      repeat (phases[p].cycles) step(1'b0, phases[p].offer, phases[p].full, 4'b1111);
    end
    drain();
    #3;
    for (int k = 0; k < NUM_REQ; k++) check("scoreboard_empty", 64'(exp_q[k].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
